// File: rtl/srgate_multi.sv
// Multi-channel set/reset gate: per-channel edge-selected SR latch with force strobes,
// simultaneous-edge priority and an optional retriggerable auto-reset timeout.
module srgate_multi #(
    parameter int unsigned NCHAN = 4,
    parameter int unsigned TW    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NCHAN-1:0]      set_i,
    input  logic [NCHAN-1:0]      reset_i,
    input  logic [2*NCHAN-1:0]    SET_EDGE,
    input  logic [2*NCHAN-1:0]    RST_EDGE,
    input  logic [NCHAN-1:0]      RST_WINS,
    input  logic [TW*NCHAN-1:0]   TIMEOUT,
    input  logic [NCHAN-1:0]      FORCE_SET_WSTB,
    input  logic [NCHAN-1:0]      FORCE_RST_WSTB,
    output logic [NCHAN-1:0]      out_o,
    output logic [NCHAN-1:0]      timeout_o
);

    typedef enum logic [1:0] {
        EDGE_RISE   = 2'd0,
        EDGE_FALL   = 2'd1,
        EDGE_EITHER = 2'd2,
        EDGE_OFF    = 2'd3
    } edge_mode_t;

    logic [NCHAN-1:0] set_prev;
    logic [NCHAN-1:0] rst_prev;
    logic             armed;
    logic [TW-1:0]    cnt [NCHAN];

    logic [NCHAN-1:0] set_ev;
    logic [NCHAN-1:0] rst_ev;
    logic [NCHAN-1:0] expire;
    logic [NCHAN-1:0] nxt_out;
    logic [NCHAN-1:0] nxt_to;
    logic [NCHAN-1:0] go_high;
    logic [NCHAN-1:0] inc_cnt;
    logic [TW-1:0]    tmo;
    logic [TW:0]      cnt_next;

    function automatic logic edge_hit(input logic [1:0] mode, input logic cur, input logic prev);
        logic hit;
        hit = 1'b0;
        case (edge_mode_t'(mode))
            EDGE_RISE:   hit = cur & ~prev;
            EDGE_FALL:   hit = ~cur & prev;
            EDGE_EITHER: hit = cur ^ prev;
            default:     hit = 1'b0;
        endcase
        return hit;
    endfunction

    always_comb begin
        set_ev   = '0;
        rst_ev   = '0;
        expire   = '0;
        nxt_out  = out_o;
        nxt_to   = '0;
        go_high  = '0;
        inc_cnt  = '0;
        tmo      = '0;
        cnt_next = '0;
        for (int unsigned k = 0; k < NCHAN; k++) begin
            tmo       = TIMEOUT[TW*k +: TW];
            cnt_next  = {1'b0, cnt[k]} + {{TW{1'b0}}, 1'b1};
            set_ev[k] = armed & edge_hit(SET_EDGE[2*k +: 2], set_i[k], set_prev[k]);
            rst_ev[k] = armed & edge_hit(RST_EDGE[2*k +: 2], reset_i[k], rst_prev[k]);
            // Width-extended compare so an all-ones counter cannot wrap past the limit
            expire[k] = out_o[k] && (tmo != '0) && (cnt_next >= {1'b0, tmo});
            if (FORCE_RST_WSTB[k]) begin
                nxt_out[k] = 1'b0;
            end else if (FORCE_SET_WSTB[k]) begin
                nxt_out[k] = 1'b1;
                go_high[k] = 1'b1;
            end else if (set_ev[k] && rst_ev[k]) begin
                nxt_out[k] = ~RST_WINS[k];
                go_high[k] = ~RST_WINS[k];
            end else if (rst_ev[k]) begin
                nxt_out[k] = 1'b0;
            end else if (set_ev[k]) begin
                nxt_out[k] = 1'b1;
                go_high[k] = 1'b1;
            end else if (expire[k]) begin
                nxt_out[k] = 1'b0;
                nxt_to[k]  = 1'b1;
            end
            inc_cnt[k] = out_o[k] && (tmo != '0) && (cnt[k] != '1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_o     <= '0;
            timeout_o <= '0;
            set_prev  <= set_i;
            rst_prev  <= reset_i;
            armed     <= 1'b0;
            for (int unsigned k = 0; k < NCHAN; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            out_o     <= nxt_out;
            timeout_o <= nxt_to;
            set_prev  <= set_i;
            rst_prev  <= reset_i;
            armed     <= 1'b1;
            for (int unsigned k = 0; k < NCHAN; k++) begin
                if (go_high[k]) begin
                    cnt[k] <= '0;
                end else if (inc_cnt[k]) begin
                    cnt[k] <= cnt[k] + {{(TW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: doc/srgate_multi.md
Name: srgate_multi

Overview:
- Multi-channel, parametrised successor to the single-channel set/reset gate.
- NCHAN independent SR latches. Each channel has:
  - programmable set/reset edge selection (rising, falling, either, disabled)
  - a simultaneous-event priority bit
  - software force-set/force-reset write strobes
  - an optional retriggerable auto-reset timeout
- Sits on the position/bit bus like other logic blocks; registers come from the block register interface.

Parameters:
- NCHAN, 4, number of independent gate channels (1..32).
- TW, 32, width of per-channel TIMEOUT field and hold counter.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  synchronous active-low reset.
- set_i  in  NCHAN  per-channel set bit-bus input.
- reset_i  in  NCHAN  per-channel reset bit-bus input.
- SET_EDGE  in  2*NCHAN  channel k at [2k+1:2k]: 0=rising, 1=falling, 2=either, 3=disabled.
- RST_EDGE  in  2*NCHAN  same encoding, for the reset input.
- RST_WINS  in  NCHAN  1: reset edge beats set edge on the same cycle; 0: set beats reset.
- TIMEOUT  in  TW*NCHAN  channel k at [TW*(k+1)-1:TW*k]; high-time limit in clocks; 0 disables.
- FORCE_SET_WSTB  in  NCHAN  single-cycle strobe; forces channel output high.
- FORCE_RST_WSTB  in  NCHAN  single-cycle strobe; forces channel output low.
- out_o  out  NCHAN  gate outputs.
- timeout_o  out  NCHAN  one-cycle pulse when a channel auto-resets on timeout.

Behaviour:
- Reset: while rst_n_i=0 at a clock edge:
  - out_o=0, timeout_o=0, all hold counters=0
  - input history registers load set_i/reset_i
  - armed flag cleared
- First cycle after reset release: armed set; no edges are detected that cycle, so no spurious edge from an input already high.
- Edge detect per channel, comparing the current input with the registered previous value:
  - rise = cur & ~prev
  - fall = ~cur & prev
  - either = rise | fall
  - disabled = never
- Latency: an edge present on set_i/reset_i in cycle n changes out_o at the clock ending cycle n (registered, 1-clock latency). Force strobes have the same latency.
- Next-state priority per channel, highest first:
  1. FORCE_RST_WSTB → 0
  2. FORCE_SET_WSTB → 1
  3. set and reset edge together → RST_WINS ? 0 : 1
  4. reset edge → 0
  5. set edge → 1 (retrigger if already high)
  6. timeout expiry → 0
  7. else hold
- Hold counter:
  - Cleared to 0 whenever out goes or is forced high, including retrigger by a set edge or FORCE_SET while high.
  - Increments each cycle while out=1 and TIMEOUT≠0.
  - Expiry when out=1, TIMEOUT≠0 and counter+1 >= TIMEOUT. Output is therefore high exactly TIMEOUT cycles after an untouched set.
  - Counter saturates; it never wraps.
- timeout_o pulses 1 cycle, coincident with out_o falling, only when the fall is caused by expiry. No pulse if a reset edge or force causes the fall in the same cycle.
- TIMEOUT changed while high: the comparison uses the live value. If counter+1 >= new value, the output drops on the next clock. Changing to 0 cancels the pending timeout.
- SET_EDGE/RST_EDGE changes take effect the next cycle. History registers always track inputs, so no false edges are generated by a mode change.
- Channels are fully independent; no cross-channel interaction.
- Reset asserted mid-operation overrides everything on that clock.

Test Plan:
1. Edge modes:
   - ch0: SET_EDGE=0, RST_EDGE=1; pulse set_i[0] high at ts 10 → out_o[0]=1 at ts 11.
   - reset_i[0] high at ts 20 → no change; falls low at ts 25 → out_o[0]=0 at ts 26.
   - Repeat with SET_EDGE=2 (either) and 3 (disabled; out never rises).
2. Simultaneous edges on ch1, set and reset both rising at ts 30:
   - RST_WINS=1 → out_o[1]=0.
   - Repeat with RST_WINS=0 → out_o[1]=1 at ts 31.
   - Same cycle with FORCE_RST_WSTB[1]=1 → 0 regardless.
3. Timeout on ch2, TIMEOUT=5, set edge at ts 40:
   - out_o[2]=1 for ts 41..45, 0 at ts 46; timeout_o[2]=1 only on the ts 46 clock.
   - Retrigger set edge at ts 43 → high until ts 48.
   - TIMEOUT=0 → stays high indefinitely.
4. Live TIMEOUT change: ch3 high with count=7; write TIMEOUT=3 → out_o[3]=0 next clock with timeout_o pulse. Reset edge in the expiry cycle → out low, timeout_o=0.
5. Reset behaviour:
   - Hold set_i=all-ones through reset release → no channel sets.
   - Assert rst_n_i=0 mid-high with counter running → out_o=0, timeout_o=0 next clock; channel set after release restarts the count from 0.
6. Channel independence with NCHAN=4: simultaneous different stimuli on all channels; each channel matches a per-channel reference model, with no crosstalk over 10k random cycles.
